// File: rtl/fft16_bf_scheduler_if.sv
// Handshake and address bus between the FFT butterfly scheduler and its neighbours
// (frame buffer, butterfly datapath, result consumer).
interface fft16_bf_scheduler_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              busy;
  logic              bf_issue;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [2:0]        tw_idx;
  logic [1:0]        stage;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_a_addr;
  logic [ADDR_W-1:0] wr_b_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [ADDR_W-1:0] out_addr;
  logic              done;

  modport master (
    input  start, out_ready,
    output busy, bf_issue, rd_a_addr, rd_b_addr, tw_idx, stage,
           wr_en, wr_a_addr, wr_b_addr, out_valid, out_idx, out_addr, done
  );

  modport slave (
    output start, out_ready,
    input  busy, bf_issue, rd_a_addr, rd_b_addr, tw_idx, stage,
           wr_en, wr_a_addr, wr_b_addr, out_valid, out_idx, out_addr, done
  );
endinterface

// File: rtl/fft16_bf_scheduler.sv
// Sequences a shared radix-2 DIF butterfly over an in-place 16-entry buffer, one
// butterfly per cycle, then unloads the results in natural frequency order.
module fft16_bf_scheduler #(
  parameter int N_PTS  = 16,
  parameter int LOG2N  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fft16_bf_scheduler_if.master  bus
);

  localparam logic [2:0] LAST_J     = 3'(N_PTS / 2 - 1);
  localparam logic [1:0] LAST_STAGE = 2'(LOG2N - 1);

  typedef enum logic [2:0] {IDLE, CALC, BUBBLE, DRAIN, OUT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        j, j_nxt;
  logic [1:0]        stg, stg_nxt;
  logic [3:0]        idx, idx_nxt;
  logic              done_nxt;

  logic              issue;
  logic              valid;
  logic [3:0]        span, mask, j4, k4, tw_full;
  logic [3:0]        rd_a, rd_b;
  logic [2:0]        tw;

  logic              wr_en_q;
  logic [3:0]        wr_a_q, wr_b_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      j       <= '0;
      stg     <= '0;
      idx     <= '0;
      wr_en_q <= 1'b0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      j       <= j_nxt;
      stg     <= stg_nxt;
      idx     <= idx_nxt;
      wr_en_q <= issue;
      wr_a_q  <= rd_a;
      wr_b_q  <= rd_b;
      done_q  <= done_nxt;
    end
  end

  // rd_a = 2*span*(j/span) + j%span, i.e. the j bits above the span boundary move up by one.
  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    stg_nxt   = stg;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    issue     = 1'b0;
    valid     = 1'b0;
    rd_a      = '0;
    rd_b      = '0;
    tw        = '0;
    span      = 4'd8 >> stg;
    mask      = span - 4'd1;
    j4        = {1'b0, j};
    k4        = j4 & mask;
    tw_full   = k4 << stg;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          j_nxt     = '0;
          stg_nxt   = '0;
        end
      end
      CALC: begin
        issue = 1'b1;
        rd_a  = ((j4 & ~mask) << 1) | k4;
        rd_b  = rd_a + span;
        tw    = tw_full[2:0];
        if (j == LAST_J) begin
          j_nxt     = '0;
          state_nxt = (stg == LAST_STAGE) ? DRAIN : BUBBLE;
        end else begin
          j_nxt = j + 3'd1;
        end
      end
      BUBBLE: begin
        stg_nxt   = stg + 2'd1;
        state_nxt = CALC;
      end
      DRAIN: begin
        idx_nxt   = '0;
        state_nxt = OUT;
      end
      OUT: begin
        valid = 1'b1;
        if (bus.out_ready) begin
          if (idx == 4'd15) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.bf_issue  = issue;
  assign bus.rd_a_addr = ADDR_W'(rd_a);
  assign bus.rd_b_addr = ADDR_W'(rd_b);
  assign bus.tw_idx    = tw;
  assign bus.stage     = stg;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_a_addr = ADDR_W'(wr_a_q);
  assign bus.wr_b_addr = ADDR_W'(wr_b_q);
  assign bus.out_valid = valid;
  assign bus.out_idx   = valid ? ADDR_W'(idx) : '0;
  // Natural-order X[k] sits at the bit-reversed address after in-place DIF.
  assign bus.out_addr  = valid ? ADDR_W'({idx[0], idx[1], idx[2], idx[3]}) : '0;
  assign bus.done      = done_q;

endmodule
